input_feeder: RTL

INPUT_FEEDER -- requirements
Module: input_feeder

---
 rtl/feeder_pkg.sv | 15 +
 rtl/feeder_fifo.sv | 74 +++++++
 rtl/input_feeder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// feeder_pkg: shared FSM state type and default sizes for the input_feeder
// serializer and its optional word FIFO.
package feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH      = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int SENT_COUNT_W       = 16;

endpackage

// File: rtl/feeder_fifo.sv
// feeder_fifo: synchronous word FIFO with registered full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module feeder_fifo
  import feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic             fast_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int             PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push  = push && !full_q;
  assign do_pop   = pop && !empty_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

  // Advance pointers and occupancy; flags are derived from the next count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // Pointer and flag registers; reset empties the FIFO.
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge fast_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/input_feeder.sv
// input_feeder: accepts parallel words and serializes them LSB first,
// followed by a one-cycle ready_out pulse per word.
// Build option: define INPUT_FEEDER_FIFO_EN to buffer words in a
// FIFO_DEPTH-entry feeder_fifo; otherwise a single holding register is used.
module input_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                    fast_clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic                    serial_out,
  output logic                    ready_out,
  output logic                    busy,
  output logic [SENT_COUNT_W-1:0] sent_count
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  if (WIDTH < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("input_feeder: WIDTH must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        shreg_q, shreg_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    serial_out_q, serial_out_d;
  logic                    ready_out_q, ready_out_d;
  logic                    busy_q, busy_d;
  logic [SENT_COUNT_W-1:0] sent_count_q, sent_count_d;
  logic                    ready_en_q;

  logic                    buf_full, buf_empty;
  logic [WIDTH-1:0]        buf_head;
  logic                    buf_push, buf_pop;
  logic                    accept, can_load, bypass;
  logic [WIDTH-1:0]        load_word;

  // A buffered word always goes first; a fresh word bypasses the buffer
  // only when the buffer is empty and the serializer can take it now.
  assign accept    = wr_valid && wr_ready;
  assign can_load  = (state_q != SHIFT);
  assign buf_pop   = can_load && !buf_empty;
  assign bypass    = can_load && buf_empty && accept;
  assign buf_push  = accept && !bypass;
  assign load_word = buf_pop ? buf_head : wr_data;

`ifdef INPUT_FEEDER_FIFO_EN
  feeder_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .push      (buf_push),
    .push_data (wr_data),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .full      (buf_full),
    .empty     (buf_empty)
  );
`else
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;

  // Single-entry holding register: a pop empties it, a push (possibly on
  // the same edge) refills it.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (buf_pop) hold_valid_d = 1'b0;
    if (buf_push) begin
      hold_valid_d = 1'b1;
      hold_data_d  = wr_data;
    end
  end

  // Holding register state.
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign buf_full  = hold_valid_q;
  assign buf_empty = !hold_valid_q;
  assign buf_head  = hold_data_q;
`endif

  // Serializer FSM: load a word, shift it out over WIDTH cycles, then a
  // single DONE cycle that may immediately chain into the next word.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    serial_out_d = 1'b0;
    ready_out_d  = 1'b0;
    sent_count_d = sent_count_q;
    case (state_q)
      IDLE, DONE: begin
        if (buf_pop || bypass) begin
          state_d      = SHIFT;
          serial_out_d = load_word[0];
          shreg_d      = load_word >> 1;
          cnt_d        = '0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          state_d      = DONE;
          ready_out_d  = 1'b1;
          sent_count_d = sent_count_q + SENT_COUNT_W'(1);
        end else begin
          serial_out_d = shreg_q[0];
          shreg_d      = shreg_q >> 1;
          cnt_d        = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A non-empty buffer always forces a load, so it implies a non-IDLE
    // next state; busy therefore follows the next state alone.
    busy_d = (state_d != IDLE);
  end

  // FSM and output registers; ready_en_q holds wr_ready low until the
  // first edge after reset is released.
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      serial_out_q <= 1'b0;
      ready_out_q  <= 1'b0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      serial_out_q <= serial_out_d;
      ready_out_q  <= ready_out_d;
      busy_q       <= busy_d;
      sent_count_q <= sent_count_d;
      ready_en_q   <= 1'b1;
    end
  end

  assign wr_ready   = ready_en_q && !buf_full;
  assign serial_out = serial_out_q;
  assign ready_out  = ready_out_q;
  assign busy       = busy_q;
  assign sent_count = sent_count_q;

endmodule
